// File: rtl/uart_link_poller.sv
// Round-robin UART poll scheduler: sends a poll byte to each link in turn over a shared
// transmitter and waits for that link's reply, with timeout, parity-retry and alive tracking.
module uart_link_poller #(
  parameter int         N_LINKS        = 4,
  parameter int         LW             = 2,
  parameter logic [3:0] POLL_CMD       = 4'hA,
  parameter int         TIMEOUT_CYCLES = 2400,
  parameter int         RETRIES        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [LW-1:0]        link_sel,
  input  logic [N_LINKS-1:0]   rx_done,
  input  logic [8*N_LINKS-1:0] rx_data,
  input  logic [N_LINKS-1:0]   rx_parity_err,
  output logic                 reply_valid,
  output logic [LW-1:0]        reply_link,
  output logic [7:0]           reply_data,
  output logic [N_LINKS-1:0]   link_alive,
  output logic                 fault_pulse,
  output logic                 round_done
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RMAX  = 3'(RETRIES);
  localparam logic [LW-1:0] LLAST = LW'(N_LINKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_RX, S_GOOD, S_DEAD, S_NEXT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [LW-1:0]        r_link_sel;
  logic [2:0]           r_retry;
  logic [TW-1:0]        r_timer;
  logic [N_LINKS-1:0]   r_rx_done_q;
  logic [N_LINKS-1:0]   r_link_alive;
  logic [LW-1:0]        r_reply_link;
  logic [7:0]           r_reply_data;

  logic [N_LINKS-1:0]   w_edge_vec;
  logic                 w_edge;
  logic                 w_perr;
  logic                 w_good;
  logic                 w_fail;
  logic                 w_can_retry;
  logic [7:0]           w_sel_data;
  logic [3:0]           w_idx4;

  // Only a rising rx_done inside WAIT_RX counts; the history register runs in every state
  // (and through reset) so stale or pre-existing levels never look like a fresh reply.
  assign w_edge_vec  = rx_done & ~r_rx_done_q;
  assign w_edge      = w_edge_vec[r_link_sel];
  assign w_perr      = rx_parity_err[r_link_sel];
  assign w_good      = w_edge && !w_perr;
  assign w_fail      = (w_edge && w_perr) || (!w_edge && (r_timer == TLAST));
  assign w_can_retry = (r_retry < RMAX);
  assign w_sel_data  = rx_data[{r_link_sel, 3'b000} +: 8];
  assign w_idx4      = 4'(r_link_sel);

  always_ff @(posedge clk) begin
    r_rx_done_q <= rx_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (enable) w_next = S_SEND;
      S_SEND:    if (tx_busy) w_next = S_WAIT_TX;
      S_WAIT_TX: if (!tx_busy) w_next = S_WAIT_RX;
      S_WAIT_RX: begin
        if (w_good) begin
          w_next = S_GOOD;
        end else if (w_fail) begin
          w_next = w_can_retry ? S_SEND : S_DEAD;
        end
      end
      S_GOOD:    w_next = S_NEXT;
      S_DEAD:    w_next = S_NEXT;
      S_NEXT:    w_next = enable ? S_SEND : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // tx_start is gated by rst so a request in flight is withdrawn in the reset cycle itself.
  always_comb begin
    tx_start    = (r_state == S_SEND) && !rst;
    tx_data     = (r_state == S_SEND) ? {POLL_CMD, w_idx4} : 8'h00;
    reply_valid = (r_state == S_GOOD);
    fault_pulse = (r_state == S_DEAD);
    round_done  = (r_state == S_NEXT) && (r_link_sel == LLAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_link_sel   <= '0;
      r_retry      <= '0;
      r_timer      <= '0;
      r_link_alive <= '0;
      r_reply_link <= '0;
      r_reply_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_retry <= '0;
        S_WAIT_TX: r_timer <= '0;
        S_WAIT_RX: begin
          r_timer <= r_timer + 1'b1;
          if (w_good) begin
            r_reply_data             <= w_sel_data;
            r_reply_link             <= r_link_sel;
            r_link_alive[r_link_sel] <= 1'b1;
          end else if (w_fail) begin
            if (w_can_retry) begin
              r_retry <= r_retry + 3'd1;
            end else begin
              r_reply_link             <= r_link_sel;
              r_link_alive[r_link_sel] <= 1'b0;
            end
          end
        end
        S_NEXT: begin
          r_retry    <= '0;
          r_link_sel <= (r_link_sel == LLAST) ? '0 : r_link_sel + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign link_sel   = r_link_sel;
  assign link_alive = r_link_alive;
  assign reply_link = r_reply_link;
  assign reply_data = r_reply_data;

endmodule

// File: tb/tb_uart_link_poller.sv
// Directed bench for uart_link_poller: a shared-tx model with fixed busy time and per-link
// reply models (good, silent, parity-then-good) drive the poller through its scenarios.
module tb_uart_link_poller;
  localparam int NL  = 4;
  localparam int TO  = 200;
  localparam int RT  = 2;
  localparam int TXL = 10;
  localparam int DLY = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  link_sel;
  logic [3:0]  rx_done;
  logic [31:0] rx_data = '0;
  logic [3:0]  rx_perr = '0;
  logic        reply_valid;
  logic [1:0]  reply_link;
  logic [7:0]  reply_data;
  logic [3:0]  link_alive;
  logic        fault_pulse;
  logic        round_done;

  logic [3:0] m_level = '0;
  logic [3:0] init_level = '0;
  logic [3:0] ovr_mask = '0;
  logic [3:0] ovr_val = '0;
  assign rx_done = (m_level & ~ovr_mask) | (ovr_val & ovr_mask);

  int         mode [NL];
  logic [7:0] rdata[NL];
  int         rdly [NL];

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  int         txc_q[$];
  logic [1:0] rv_link[$];
  logic [7:0] rv_data[$];
  int         rv_cyc[$];
  logic [1:0] flt_q[$];
  int         rnd_cnt = 0;
  int         att[NL];
  int         bcnt = 0;
  int         rcnt = 0;
  int         rlnk = 0;
  int         tx_lnk = 0;
  logic       rpend = 1'b0;
  logic       bad;

  uart_link_poller #(
    .N_LINKS(NL), .LW(2), .POLL_CMD(4'hA), .TIMEOUT_CYCLES(TO), .RETRIES(RT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .link_sel(link_sel),
    .rx_done(rx_done), .rx_data(rx_data), .rx_parity_err(rx_perr),
    .reply_valid(reply_valid), .reply_link(reply_link), .reply_data(reply_data),
    .link_alive(link_alive), .fault_pulse(fault_pulse), .round_done(round_done)
  );

  always #5 clk = ~clk;

  // Link/transmitter model and monitors, all on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        tx_q.delete(); txc_q.delete(); rv_link.delete(); rv_data.delete();
        rv_cyc.delete(); flt_q.delete();
        rnd_cnt = 0; tx_busy = 1'b0; bcnt = 0; rpend = 1'b0;
        m_level = init_level; rx_perr = '0; rx_data = '0;
        for (int i = 0; i < NL; i++) att[i] = 0;
      end else begin
        if (reply_valid) begin
          rv_link.push_back(reply_link); rv_data.push_back(reply_data); rv_cyc.push_back(cyc);
        end
        if (fault_pulse) flt_q.push_back(reply_link);
        if (round_done) rnd_cnt++;
        if (rpend) begin
          rcnt--;
          if (rcnt == 0) begin
            bad = (mode[rlnk] == 2) && (att[rlnk] == 1);
            rx_data[8*rlnk +: 8] = bad ? 8'hEE : rdata[rlnk];
            rx_perr[rlnk] = bad;
            m_level[rlnk] = 1'b1;
            rpend = 1'b0;
          end
        end
        if (tx_busy) begin
          bcnt--;
          if (bcnt == 0) begin
            tx_busy = 1'b0;
            if (mode[tx_lnk] != 0) begin
              m_level[tx_lnk] = 1'b0;
              rpend = 1'b1; rcnt = rdly[tx_lnk]; rlnk = tx_lnk;
            end
          end
        end else if (tx_start) begin
          tx_q.push_back(tx_data); txc_q.push_back(cyc);
          tx_busy = 1'b1; bcnt = TXL;
          tx_lnk = int'(tx_data[1:0]);
          att[tx_lnk]++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_all_good();
    for (int i = 0; i < NL; i++) begin
      mode[i] = 1; rdata[i] = 8'h10 + 8'(i); rdly[i] = DLY;
    end
  endtask

  task automatic do_reset(input logic [3:0] lvl);
    init_level = lvl; ovr_mask = '0; ovr_val = '0;
    enable = 1'b0; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_rounds(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (rnd_cnt >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_tx(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (tx_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1;
    repeat (3) tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (link_sel !== 2'd0) begin errors++; $display("FAIL reset_link_sel: got %0d want 0", link_sel); end
    checks++; if ({reply_valid, fault_pulse, round_done} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {reply_valid, fault_pulse, round_done}); end
    checks++; if (link_alive !== 4'b0000) begin errors++; $display("FAIL reset_alive: got %b want 0000", link_alive); end
    checks++; if ({reply_link, reply_data} !== 10'd0) begin errors++; $display("FAIL reset_reply: got link %0d data %h want 0/00", reply_link, reply_data); end
    enable = 1'b0; rst = 1'b0;
  endtask

  task automatic test_round();
    bit ok;
    set_all_good(); do_reset(4'b0000);
    enable = 1'b1; wait_rounds(1, 1500, ok); enable = 1'b0;
    repeat (20) tick();
    checks++; if (!ok) begin errors++; $display("FAIL round_timeout: round_done count %0d want 1", rnd_cnt); end
    checks++; if (rv_link.size() != 4 || tx_q.size() != 4) begin errors++; $display("FAIL round_counts: got %0d replies %0d tx want 4/4", rv_link.size(), tx_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rv_link[i] !== 2'(i) || rv_data[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL round_reply%0d: got link %0d data %h want %0d/%h", i, rv_link[i], rv_data[i], i, 8'h10 + 8'(i)); end
        checks++; if (tx_q[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL round_tx%0d: got %h want %h", i, tx_q[i], 8'hA0 + 8'(i)); end
      end
      checks++; if (rv_cyc[0] - txc_q[0] != TXL + DLY + 1) begin errors++; $display("FAIL round_latency: got %0d want %0d", rv_cyc[0] - txc_q[0], TXL + DLY + 1); end
      checks++; if (txc_q[1] - txc_q[0] != TXL + DLY + 3) begin errors++; $display("FAIL round_link_gap: got %0d want %0d", txc_q[1] - txc_q[0], TXL + DLY + 3); end
    end
    checks++; if (link_alive !== 4'b1111) begin errors++; $display("FAIL round_alive: got %b want 1111", link_alive); end
    checks++; if (flt_q.size() != 0 || rnd_cnt != 1) begin errors++; $display("FAIL round_misc: got %0d faults %0d rounds want 0/1", flt_q.size(), rnd_cnt); end
  endtask

  task automatic test_timeout_retry();
    bit ok;
    logic [7:0] exp_tx[6];
    exp_tx = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA3};
    set_all_good(); mode[2] = 0; do_reset(4'b0000);
    enable = 1'b1; wait_rounds(1, 3000, ok); enable = 1'b0;
    repeat (20) tick();
    checks++; if (!ok) begin errors++; $display("FAIL retry_timeout: round_done count %0d want 1", rnd_cnt); end
    checks++; if (tx_q.size() != 6) begin errors++; $display("FAIL retry_tx_count: got %0d want 6", tx_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (tx_q[i] !== exp_tx[i]) begin errors++; $display("FAIL retry_tx%0d: got %h want %h", i, tx_q[i], exp_tx[i]); end
      end
      checks++; if (txc_q[3] - txc_q[2] != TXL + TO + 1 || txc_q[4] - txc_q[3] != TXL + TO + 1) begin errors++; $display("FAIL retry_gap: got %0d,%0d want %0d", txc_q[3] - txc_q[2], txc_q[4] - txc_q[3], TXL + TO + 1); end
      checks++; if (txc_q[5] - txc_q[4] != TXL + TO + 3) begin errors++; $display("FAIL retry_dead_gap: got %0d want %0d", txc_q[5] - txc_q[4], TXL + TO + 3); end
    end
    checks++; if (flt_q.size() != 1 || flt_q[0] !== 2'd2) begin errors++; $display("FAIL retry_fault: got %0d faults first link %0d want 1 on link 2", flt_q.size(), (flt_q.size() > 0) ? flt_q[0] : 2'd0); end
    checks++; if (rv_link.size() != 3 || rv_link[2] !== 2'd3 || rv_data[2] !== 8'h13) begin errors++; $display("FAIL retry_replies: got %0d replies want 3 ending link 3 data 13", rv_link.size()); end
    checks++; if (link_alive !== 4'b1011) begin errors++; $display("FAIL retry_alive: got %b want 1011", link_alive); end
  endtask

  task automatic test_parity_retry();
    bit ok;
    logic [7:0] exp_tx[5];
    logic [7:0] exp_rd[4];
    exp_tx = '{8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA3};
    exp_rd = '{8'h10, 8'h55, 8'h12, 8'h13};
    set_all_good(); mode[1] = 2; rdata[1] = 8'h55; do_reset(4'b0000);
    enable = 1'b1; wait_rounds(1, 2000, ok); enable = 1'b0;
    repeat (20) tick();
    checks++; if (!ok) begin errors++; $display("FAIL parity_timeout: round_done count %0d want 1", rnd_cnt); end
    checks++; if (tx_q.size() != 5 || rv_link.size() != 4) begin errors++; $display("FAIL parity_counts: got %0d tx %0d replies want 5/4", tx_q.size(), rv_link.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (tx_q[i] !== exp_tx[i]) begin errors++; $display("FAIL parity_tx%0d: got %h want %h", i, tx_q[i], exp_tx[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        checks++; if (rv_link[i] !== 2'(i) || rv_data[i] !== exp_rd[i]) begin errors++; $display("FAIL parity_reply%0d: got link %0d data %h want %0d/%h", i, rv_link[i], rv_data[i], i, exp_rd[i]); end
      end
      checks++; if (txc_q[2] - txc_q[1] != TXL + DLY + 1) begin errors++; $display("FAIL parity_gap: got %0d want %0d", txc_q[2] - txc_q[1], TXL + DLY + 1); end
    end
    checks++; if (flt_q.size() != 0 || link_alive !== 4'b1111) begin errors++; $display("FAIL parity_status: got %0d faults alive %b want 0/1111", flt_q.size(), link_alive); end
  endtask

  task automatic test_held_rx_done();
    bit ok;
    int n0;
    set_all_good(); do_reset(4'b0001);
    repeat (10) tick();
    checks++; if (rv_link.size() != 0) begin errors++; $display("FAIL held_idle_reply: got %0d replies want 0", rv_link.size()); end
    enable = 1'b1; wait_rounds(1, 1500, ok); enable = 1'b0;
    repeat (20) tick();
    n0 = 0;
    foreach (rv_link[i]) if (rv_link[i] == 2'd0) n0++;
    checks++; if (!ok || n0 != 1 || rv_link.size() != 4) begin errors++; $display("FAIL held_reply_count: got %0d link0 replies %0d total want 1/4", n0, rv_link.size()); end
    checks++; if (rv_cyc.size() == 0 || txc_q.size() == 0 || rv_cyc[0] - txc_q[0] != TXL + DLY + 1) begin errors++; $display("FAIL held_latency: first reply not at tx+%0d", TXL + DLY + 1); end
  endtask

  task automatic test_edge_vs_timeout();
    bit ok;
    set_all_good(); rdly[0] = TO; do_reset(4'b0000);
    enable = 1'b1; wait_rounds(1, 2000, ok); enable = 1'b0;
    repeat (20) tick();
    checks++; if (!ok || tx_q.size() != 4 || flt_q.size() != 0) begin errors++; $display("FAIL tie_counts: got %0d tx %0d faults want 4/0", tx_q.size(), flt_q.size()); end
    checks++; if (rv_link.size() == 0 || rv_link[0] !== 2'd0 || rv_data[0] !== 8'h10 || rv_cyc[0] - txc_q[0] != TXL + TO + 1) begin errors++; $display("FAIL tie_reply: link 0 reply missing or not at tx+%0d", TXL + TO + 1); end
  endtask

  task automatic test_other_link();
    bit ok;
    logic [7:0] exp_tx[6];
    exp_tx = '{8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3};
    set_all_good(); mode[1] = 0; do_reset(4'b0000);
    enable = 1'b1; wait_tx(2, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL other_wait_tx: got %0d tx want 2", tx_q.size()); end
    else begin
      while (cyc < txc_q[1] + TXL + 30) tick();
      ovr_val[3] = 1'b1; ovr_mask[3] = 1'b1;
      repeat (20) tick();
      ovr_mask[3] = 1'b0;
    end
    wait_rounds(1, 3000, ok); enable = 1'b0;
    repeat (20) tick();
    checks++; if (!ok || tx_q.size() != 6) begin errors++; $display("FAIL other_tx_count: got %0d want 6", tx_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (tx_q[i] !== exp_tx[i]) begin errors++; $display("FAIL other_tx%0d: got %h want %h", i, tx_q[i], exp_tx[i]); end
      end
    end
    checks++; if (rv_link.size() != 3 || rv_link[1] !== 2'd2 || rv_link[2] !== 2'd3 || rv_data[2] !== 8'h13) begin errors++; $display("FAIL other_replies: got %0d replies want links 0,2,3", rv_link.size()); end
    checks++; if (flt_q.size() != 1 || flt_q[0] !== 2'd1) begin errors++; $display("FAIL other_fault: got %0d faults want 1 on link 1", flt_q.size()); end
    checks++; if (link_alive !== 4'b1101) begin errors++; $display("FAIL other_alive: got %b want 1101", link_alive); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_all_good(); do_reset(4'b0000);
    enable = 1'b1; wait_tx(3, 800, ok);
    repeat (3) tick();
    checks++; if (!ok || link_sel !== 2'd2 || link_alive !== 4'b0011) begin errors++; $display("FAIL rstmid_pre: got sel %0d alive %b want 2/0011", link_sel, link_alive); end
    rst = 1'b1;
    tick();
    checks++; if (tx_start !== 1'b0 || link_sel !== 2'd0 || link_alive !== 4'b0000) begin errors++; $display("FAIL rstmid_state: got tx_start %b sel %0d alive %b want 0/0/0000", tx_start, link_sel, link_alive); end
    checks++; if (reply_link !== 2'd0 || reply_data !== 8'h00) begin errors++; $display("FAIL rstmid_reply: got %0d/%h want 0/00", reply_link, reply_data); end
    rst = 1'b0;
    wait_tx(1, 50, ok);
    checks++; if (!ok || tx_q[0] !== 8'hA0) begin errors++; $display("FAIL rstmid_restart: first tx after reset not A0 (%0d seen)", tx_q.size()); end
    enable = 1'b0;
    repeat (150) tick();
  endtask

  task automatic test_enable_drop();
    bit ok;
    set_all_good(); do_reset(4'b0000);
    enable = 1'b1; wait_tx(2, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_wait_tx: got %0d tx want 2", tx_q.size()); end
    else while (cyc < txc_q[1] + TXL + 20) tick();
    enable = 1'b0;
    repeat (400) tick();
    checks++; if (tx_q.size() != 2 || tx_start !== 1'b0) begin errors++; $display("FAIL endrop_tx: got %0d tx start %b want 2/0", tx_q.size(), tx_start); end
    checks++; if (rv_link.size() != 2 || rv_link[1] !== 2'd1 || rv_data[1] !== 8'h11) begin errors++; $display("FAIL endrop_reply: got %0d replies want 2 ending link 1 data 11", rv_link.size()); end
    checks++; if (link_sel !== 2'd2 || rnd_cnt != 0 || link_alive !== 4'b0011) begin errors++; $display("FAIL endrop_state: got sel %0d rounds %0d alive %b want 2/0/0011", link_sel, rnd_cnt, link_alive); end
  endtask

  initial begin
    set_all_good();
    test_reset();
    test_round();
    test_timeout_retry();
    test_parity_retry();
    test_held_rx_done();
    test_edge_vs_timeout();
    test_other_link();
    test_reset_mid();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
